// File: rtl/gs_row_mem.sv
// Row-organised matrix store for the Gaussian-elimination engine, with a fixed-latency
// engine read port and a host LOAD/DUMP streaming port usable while the engine is idle.
module gs_row_mem #(
    parameter int k          = 4,
    parameter int l          = 4,
    parameter int READ_DELAY = 2,
    // one spare address bit so out-of-range rows (>= k) can be presented and read as 0
    localparam int AW        = $clog2(k + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eng_en,
    input  logic [AW-1:0] mem_addr,
    input  logic          mem_rw,
    input  logic [l-1:0]  mem_wdata,
    output logic [l-1:0]  mem_din,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [l-1:0]  load_data,
    output logic          load_ready,
    input  logic          dump_start,
    output logic          dump_valid,
    output logic [l-1:0]  dump_data,
    input  logic          dump_ready,
    output logic          busy,
    output logic          err
);
    localparam int RW = (k > 1) ? $clog2(k) : 1;
    localparam int CW = $clog2(k + 1);
    localparam int D  = READ_DELAY + 1;
    localparam int PW = $clog2(D);
    localparam int OW = $clog2(D + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DUMP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rc_q, rc_d, ic_q, ic_d, pc_q, pc_d;
    logic          err_q, err_d;
    logic          flush;

    logic [l-1:0]  rows_q [k];
    logic [l-1:0]  eng_pipe_q [READ_DELAY];
    logic [l-1:0]  host_pipe_q [READ_DELAY];
    logic [READ_DELAY-1:0] host_vld_q;
    logic [l-1:0]  fifo_q [D];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, inflight;

    logic          addr_ok, eng_wr, load_fire, issue, push, pop;
    logic [RW-1:0] eng_row;
    logic [l-1:0]  eng_rd_val, host_rd_val;

    assign addr_ok     = mem_addr < AW'(k);
    assign eng_row     = mem_addr[RW-1:0];
    assign eng_wr      = eng_en && mem_rw && addr_ok;
    assign eng_rd_val  = (eng_en && !mem_rw && addr_ok) ? rows_q[eng_row] : '0;
    assign host_rd_val = rows_q[ic_q[RW-1:0]];

    assign busy       = (state_q != ST_IDLE);
    assign load_ready = (state_q == ST_LOAD) && !eng_en;
    assign load_fire  = load_valid && load_ready;
    assign dump_valid = (occ_q != '0);
    assign dump_data  = dump_valid ? fifo_q[rd_ptr_q] : '0;
    assign pop        = dump_valid && dump_ready;
    assign push       = host_vld_q[READ_DELAY-1];
    assign mem_din    = eng_pipe_q[READ_DELAY-1];
    assign err        = err_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_DELAY; i++) begin
            inflight = inflight + OW'(host_vld_q[i]);
        end
    end

    // credit counts the slot freed by this cycle's pop so a ready host sees one row per cycle
    assign issue = (state_q == ST_DUMP) && !eng_en && (ic_q < CW'(k))
                   && ((occ_q + inflight - OW'(pop)) < OW'(D));

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        ic_d    = ic_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start || dump_start) begin
                    if (eng_en) begin
                        err_d = 1'b1;
                    end else if (load_start) begin
                        state_d = ST_LOAD;
                        rc_d    = '0;
                    end else begin
                        state_d = ST_DUMP;
                        ic_d    = '0;
                        pc_d    = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (eng_en) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (load_fire) begin
                    rc_d = (rc_q < CW'(k)) ? rc_q + CW'(1) : rc_q;
                    if (rc_q == CW'(k - 1)) state_d = ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (eng_en) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    flush   = 1'b1;
                end else begin
                    if (issue) ic_d = ic_q + CW'(1);
                    if (pop) begin
                        pc_d = (pc_q < CW'(k)) ? pc_q + CW'(1) : pc_q;
                        if (pc_q == CW'(k - 1)) begin
                            state_d = ST_IDLE;
                            flush   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            ic_q    <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            ic_q    <= ic_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < k; i++) rows_q[i] <= '0;
        end else if (eng_wr) begin
            rows_q[eng_row] <= mem_wdata;
        end else if (load_fire) begin
            rows_q[rc_q[RW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_DELAY; i++) begin
                eng_pipe_q[i]  <= '0;
                host_pipe_q[i] <= '0;
            end
            host_vld_q <= '0;
        end else begin
            eng_pipe_q[0]  <= eng_rd_val;
            host_pipe_q[0] <= host_rd_val;
            host_vld_q[0]  <= issue;
            for (int i = 1; i < READ_DELAY; i++) begin
                eng_pipe_q[i]  <= eng_pipe_q[i-1];
                host_pipe_q[i] <= host_pipe_q[i-1];
                host_vld_q[i]  <= host_vld_q[i-1] && !flush;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) fifo_q[wr_ptr_q] <= host_pipe_q[READ_DELAY-1];
    end

endmodule
